prog_counter: RTL

- Parametrised successor to the fixed 10 Hz / mod-10000 up-counter feeding the SPI/FND path.
- An internal prescaler generates a count-step enable every DIV running clock cycles.
- The counter is modulo-MODULO and adds up/down direction, a wrap-or-saturate mode, a synchronous parallel load, a one-cycle wrap pulse and a limit flag.
- Sits between the control FSM (clear/run/load) and the SPI transmitter, which samples count.

---
 rtl/prog_counter_pkg.sv | 15 +
 rtl/prog_counter_if.sv | 34 +++
 rtl/prog_counter_prescaler.sv | 56 +++++
 rtl/prog_counter.sv | 107 ++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg
// Shared types and default constants for the programmable count-step counter.
//   dir_e           : count direction encoding (matches the dir port level)
//   mode_e          : limit behaviour encoding (matches the sat_mode port level)
//   DIV_10HZ_100MHZ : default prescaler ratio, one step every 100 ms at 100 MHz
//   MOD_4DIGIT      : default modulus for a four-digit display
package prog_counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

    localparam int DIV_10HZ_100MHZ = 10_000_000;
    localparam int MOD_4DIGIT      = 10_000;

endpackage

// File: rtl/prog_counter_if.sv
// prog_counter_if
// Control/status bundle between the control FSM, the counter and the SPI
// transmitter.
//   clear, run_stop, dir, sat_mode, load, load_value : control (master -> slave)
//   count, wrap_tick, at_limit                       : status  (slave -> master)
// MODULO must match the MODULO of the attached prog_counter.
interface prog_counter_if
    import prog_counter_pkg::*;
#(
    parameter int MODULO = MOD_4DIGIT
);
    localparam int WIDTH = $clog2(MODULO);

    logic             clear;
    logic             run_stop;
    logic             dir;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             wrap_tick;
    logic             at_limit;

    modport master (
        output clear, run_stop, dir, sat_mode, load, load_value,
        input  count, wrap_tick, at_limit
    );

    modport slave (
        input  clear, run_stop, dir, sat_mode, load, load_value,
        output count, wrap_tick, at_limit
    );

endinterface

// File: rtl/prog_counter_prescaler.sv
// prog_prescaler
// Divides the running clock into a count-step enable: while run_stop is high
// the phase counter walks 0..DIV-1 and step_en is high on the last phase.
// While paused the phase is frozen, so no partial interval is lost.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart of the phase at 0
//   reload     : synchronous restart of the phase at 0 (driven from load)
//   run_stop   : 1 = advance phase, 0 = hold phase
//   step_en    : combinational step enable for the counter
module prog_prescaler #(
    parameter int DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic reload,
    input  logic run_stop,
    output logic step_en
);
    // A one-bit phase register is kept for DIV=1; it simply stays at zero.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_ZERO    = {PW{1'b0}};
    localparam logic [PW-1:0] PH_ONE     = PW'(1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign step_en = run_stop && (phase_q == LAST_PHASE);

    // Next phase: restart, advance with rollover, or hold.
    always_comb begin
        phase_d = phase_q;
        if (clear || reload) begin
            phase_d = PH_ZERO;
        end else if (run_stop) begin
            if (phase_q == LAST_PHASE) begin
                phase_d = PH_ZERO;
            end else begin
                phase_d = phase_q + PH_ONE;
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_ZERO;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// prog_counter
// Modulo-MODULO up/down counter advanced once every DIV running clocks.
// Supports wrap or saturate at the limit, a clamped synchronous load, a
// one-cycle wrap pulse aligned with the wrapped count, and a limit flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control inputs and count/wrap_tick/at_limit outputs (slave side)
// Edge priority: clear > load > step > hold.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int DIV    = DIV_10HZ_100MHZ,
    parameter int MODULO = MOD_4DIGIT
) (
    input  logic            clk,
    input  logic            rst_n,
    prog_counter_if.slave   bus
);
    localparam int WIDTH = $clog2(MODULO);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_tick_q;
    logic             wrap_tick_d;
    logic             at_limit_q;
    logic             at_limit_d;
    logic             step_en_s;
    dir_e             dir_s;
    mode_e            mode_s;

    assign dir_s  = dir_e'(bus.dir);
    assign mode_s = mode_e'(bus.sat_mode);

    prog_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.clear),
        .reload   (bus.load),
        .run_stop (bus.run_stop),
        .step_en  (step_en_s)
    );

    // Values at or above MODULO are not representable counts; pin them to the top.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        if (value > MAX_CNT) begin
            return MAX_CNT;
        end else begin
            return value;
        end
    endfunction

    // Next count and wrap pulse; at_limit follows the next count with the current dir.
    always_comb begin
        count_d     = count_q;
        wrap_tick_d = 1'b0;
        if (bus.clear) begin
            count_d = ZERO;
        end else if (bus.load) begin
            count_d = clamp_load(bus.load_value);
        end else if (step_en_s) begin
            if (dir_s == DIR_UP) begin
                if (count_q < MAX_CNT) begin
                    count_d = count_q + ONE;
                end else if (mode_s == MODE_WRAP) begin
                    count_d     = ZERO;
                    wrap_tick_d = 1'b1;
                end else begin
                    count_d = count_q;
                end
            end else begin
                if (count_q > ZERO) begin
                    count_d = count_q - ONE;
                end else if (mode_s == MODE_WRAP) begin
                    count_d     = MAX_CNT;
                    wrap_tick_d = 1'b1;
                end else begin
                    count_d = count_q;
                end
            end
        end else begin
            count_d = count_q;
        end
        at_limit_d = (dir_s == DIR_UP) ? (count_d == MAX_CNT) : (count_d == ZERO);
    end

    // Count and status registers; at_limit resets high because 0 is the down limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= ZERO;
            wrap_tick_q <= 1'b0;
            at_limit_q  <= 1'b1;
        end else begin
            count_q     <= count_d;
            wrap_tick_q <= wrap_tick_d;
            at_limit_q  <= at_limit_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.wrap_tick = wrap_tick_q;
    assign bus.at_limit  = at_limit_q;

endmodule
